// File: rtl/can_vend_ctrl.sv
// rtl/can_vend_ctrl.sv - coin credit, vend/reload arbitration and motor/chute sequencing
// Drives the can counter with registered one-cycle load/dispense pulses.
module can_vend_ctrl #(
  parameter int PRICE        = 3,
  parameter int MOTOR_CYCLES = 4,
  parameter int DROP_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_coin,
  input  logic       i_vend_req,
  input  logic       i_svc_load,
  input  logic [7:0] i_svc_count,
  input  logic       i_can_empty,
  input  logic       i_chute_sensor,
  output logic       o_load,
  output logic [7:0] o_count,
  output logic       o_dispense,
  output logic       o_motor_on,
  output logic       o_vend_ok,
  output logic       o_vend_fail,
  output logic [7:0] o_credit,
  output logic       o_busy
);

  generate
    if (PRICE < 1 || PRICE > 255) begin : g_bad_price
      $error("can_vend_ctrl: PRICE must be in 1..255");
    end
  endgenerate

  localparam int         MCW    = $clog2(MOTOR_CYCLES + 1);
  localparam int         DCW    = $clog2(DROP_TIMEOUT + 1);
  localparam logic [7:0] PRICE8 = 8'(PRICE);
  localparam logic [8:0] PRICE9 = 9'(PRICE);

  typedef enum logic [1:0] {S_IDLE, S_DISP, S_MOTOR, S_WAIT_DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_load, w_load_nxt;
  logic [7:0]       r_count, w_count_nxt;
  logic             r_dispense, w_dispense_nxt;
  logic             r_motor_on, w_motor_on_nxt;
  logic             r_vend_ok, w_vend_ok_nxt;
  logic             r_vend_fail, w_vend_fail_nxt;
  logic [7:0]       r_credit, w_credit_nxt;
  logic             r_busy, w_busy_nxt;
  logic [MCW-1:0]   r_mcnt, w_mcnt_nxt;
  logic [DCW-1:0]   r_dcnt, w_dcnt_nxt;
  logic             r_hit, w_hit_nxt;
  logic [8:0]       w_credit9;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_count     <= 8'd0;
      r_dispense  <= 1'b0;
      r_motor_on  <= 1'b0;
      r_vend_ok   <= 1'b0;
      r_vend_fail <= 1'b0;
      r_credit    <= 8'd0;
      r_busy      <= 1'b0;
      r_mcnt      <= '0;
      r_dcnt      <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load      <= w_load_nxt;
      r_count     <= w_count_nxt;
      r_dispense  <= w_dispense_nxt;
      r_motor_on  <= w_motor_on_nxt;
      r_vend_ok   <= w_vend_ok_nxt;
      r_vend_fail <= w_vend_fail_nxt;
      r_credit    <= w_credit_nxt;
      r_busy      <= w_busy_nxt;
      r_mcnt      <= w_mcnt_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_hit       <= w_hit_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_nxt      = 1'b0;
    w_count_nxt     = r_count;
    w_dispense_nxt  = 1'b0;
    w_motor_on_nxt  = 1'b0;
    w_vend_ok_nxt   = 1'b0;
    w_vend_fail_nxt = 1'b0;
    w_mcnt_nxt      = r_mcnt;
    w_dcnt_nxt      = r_dcnt;
    w_hit_nxt       = r_hit;
    // 9-bit sum so a coin at 255 or a refund can be clamped afterwards
    w_credit9       = {1'b0, r_credit} + {8'd0, i_coin};

    case (r_state)
      S_IDLE: begin
        w_hit_nxt = 1'b0;
        if (i_svc_load) begin
          w_load_nxt  = 1'b1;
          w_count_nxt = i_svc_count;
        end else if (i_vend_req) begin
          // eligibility is judged on registered credit, ignoring a same-cycle coin
          if (r_credit >= PRICE8 && !i_can_empty) begin
            w_dispense_nxt = 1'b1;
            w_credit9      = w_credit9 - PRICE9;
            w_state_nxt    = S_DISP;
          end else begin
            w_vend_fail_nxt = 1'b1;
          end
        end
      end
      S_DISP: begin
        w_motor_on_nxt = 1'b1;
        w_mcnt_nxt     = MCW'(MOTOR_CYCLES);
        w_state_nxt    = S_MOTOR;
      end
      S_MOTOR: begin
        if (i_chute_sensor) w_hit_nxt = 1'b1;
        if (r_mcnt == MCW'(1)) begin
          w_dcnt_nxt  = DCW'(DROP_TIMEOUT);
          w_state_nxt = S_WAIT_DROP;
        end else begin
          w_motor_on_nxt = 1'b1;
          w_mcnt_nxt     = r_mcnt - MCW'(1);
        end
      end
      S_WAIT_DROP: begin
        // a can seen on the expiry cycle still counts as delivered
        if (i_chute_sensor || r_hit) begin
          w_vend_ok_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (r_dcnt == DCW'(1)) begin
          w_vend_fail_nxt = 1'b1;
          w_credit9       = w_credit9 + PRICE9;
          w_state_nxt     = S_IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt - DCW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_credit_nxt = w_credit9[8] ? 8'hFF : w_credit9[7:0];
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  assign o_load      = r_load;
  assign o_count     = r_count;
  assign o_dispense  = r_dispense;
  assign o_motor_on  = r_motor_on;
  assign o_vend_ok   = r_vend_ok;
  assign o_vend_fail = r_vend_fail;
  assign o_credit    = r_credit;
  assign o_busy      = r_busy;

endmodule
